// File: rtl/rangefinder_capture_pkg.sv
// Shared types and helpers for the rangefinder sample capture block.
// Contents: capture FSM state enum, default widths/timeout, and the
// record-length clamp used when cfg_length is latched at trigger.
package rangefinder_capture_pkg;

  localparam int ADDR_W_DEF         = 8;
  localparam int DATA_W_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // A length of 0 or anything above the RAM depth means "fill the whole RAM".
  function automatic int unsigned eff_length(input int unsigned cfg_length,
                                             input int unsigned depth);
    return ((cfg_length == 0) || (cfg_length > depth)) ? depth : cfg_length;
  endfunction

endpackage

// File: rtl/rangefinder_capture_peak.sv
// Peak tracker for the capture record (built only with RANGEFINDER_CAPTURE_PEAK_EN).
// Watches the RAM write strobe and keeps the largest sample written so far and
// its address. A later equal sample does not replace the earlier one.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero the peak (asserted on the trigger cycle)
//   wr_en        RAM write strobe
//   wr_addr      RAM write address
//   wr_data      RAM write data
//   peak_value   largest sample in the current/last record
//   peak_addr    address of the first occurrence of peak_value
`ifdef RANGEFINDER_CAPTURE_PEAK_EN
module rangefinder_capture_peak #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_addr
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      peak_value <= '0;
      peak_addr  <= '0;
    end else if (wr_en && (wr_data > peak_value)) begin
      peak_value <= wr_data;
      peak_addr  <= wr_addr;
    end
  end

endmodule
`endif

// File: rtl/rangefinder_sample_capture.sv
// Write-side master for the dual-port sample RAM. After arm and a laser-fire
// trigger, ADC samples are written sequentially to RAM port 2 starting at
// address 0 until the configured record length is reached, the capture times
// out, or abort is pulsed.
// Optional feature macro: RANGEFINDER_CAPTURE_PEAK_EN adds peak_value/peak_addr.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   arm             pulse: IDLE/DONE -> ARMED, clears done/error
//   abort           pulse: any state -> IDLE
//   trigger         starts capture when ARMED; cfg_length latched here
//   cfg_length      samples per record (0 or > depth means full depth)
//   sample_valid    ADC sample strobe
//   sample_data     ADC sample
//   ram_*           RAM port 2 (address/chipselect/write/writedata/clken)
//   busy            ARMED or CAPTURE
//   done, error     sticky completion / timeout flags
//   wr_count        samples written in the current/last record
//   peak_value/addr (with RANGEFINDER_CAPTURE_PEAK_EN) record maximum
//
// state      | meaning
// ST_IDLE    | waiting for arm
// ST_ARMED   | waiting for trigger
// ST_CAPTURE | writing samples, timeout timer running
// ST_DONE    | record complete, waiting for re-arm
module rangefinder_sample_capture
  import rangefinder_capture_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              trigger,
  input  logic [ADDR_W:0]   cfg_length,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [DATA_W-1:0] ram_writedata,
  output logic              ram_clken,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   wr_count
`ifdef RANGEFINDER_CAPTURE_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_value,
  output logic [ADDR_W-1:0] peak_addr
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [TW-1:0]   timer_q;
  logic            start, accept, finish, timeout, clear_flags;

  assign ram_clken = 1'b1;
  assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // The cycle after the last accepted sample is still CAPTURE (the write strobe
  // is on the bus); further samples are refused by the wr_count == len_q check,
  // and done is raised on the way to ST_DONE so it trails the final strobe.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    accept      = 1'b0;
    finish      = 1'b0;
    timeout     = 1'b0;
    clear_flags = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    case (state_q)
      ST_IDLE:  if (arm) state_d = ST_ARMED;
      ST_ARMED: begin
        if (trigger) begin
          state_d = ST_CAPTURE;
          start   = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (wr_count == len_q) begin
          state_d = ST_DONE;
          finish  = 1'b1;
        end else if (sample_valid) begin
          accept = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          state_d = ST_IDLE;
          timeout = 1'b1;
        end
      end
      ST_DONE:  if (arm) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      start       = 1'b0;
      accept      = 1'b0;
      finish      = 1'b0;
      timeout     = 1'b0;
      clear_flags = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
      wr_count       <= '0;
      len_q          <= '0;
      timer_q        <= '0;
    end else begin
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      if (clear_flags) begin
        done  <= 1'b0;
        error <= 1'b0;
      end
      if (start) begin
        len_q    <= (ADDR_W + 1)'(eff_length(32'(cfg_length), DEPTH));
        wr_count <= '0;
        timer_q  <= '0;
      end
      // The write address is the running count: records always start at 0.
      if (accept) begin
        ram_chipselect <= 1'b1;
        ram_write      <= 1'b1;
        ram_address    <= wr_count[ADDR_W-1:0];
        ram_writedata  <= sample_data;
        wr_count       <= wr_count + 1'b1;
        timer_q        <= '0;
      end else if (state_q == ST_CAPTURE) begin
        timer_q <= timer_q + 1'b1;
      end
      if (finish)  done  <= 1'b1;
      if (timeout) error <= 1'b1;
    end
  end

`ifdef RANGEFINDER_CAPTURE_PEAK_EN
  rangefinder_capture_peak #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_peak (
    .clk        (clk),
    .reset      (reset),
    .clear      (start),
    .wr_en      (ram_write),
    .wr_addr    (ram_address),
    .wr_data    (ram_writedata),
    .peak_value (peak_value),
    .peak_addr  (peak_addr)
  );
`else
  // Peak tracking not built.
`endif

endmodule
